// File: rtl/rom.sv
// Hex-digit to seven-segment lookup ROM.
// One-cycle registered read, selectable segment polarity.
module rom #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] addr,
  input  logic       en,
  output logic [6:0] data,
  output logic       data_valid
);

  // All segments off in the selected polarity; also the inversion mask.
  localparam logic [6:0] BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [6:0] seg;

  always_comb begin
    seg = 7'h00;
    unique case (addr)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= BLANK;
      data_valid <= 1'b0;
    end else if (en) begin
      data       <= seg ^ BLANK;
      data_valid <= 1'b1;
    end else begin
      data       <= BLANK;
      data_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom.sv
// Bench for rom: directed vector table plus randomized run
// against a table-lookup model; both polarities instantiated.
module tb_rom;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] addr;
  logic       en;
  logic [6:0] data_h, data_l;
  logic       vld_h, vld_l;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rom #(.ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .addr(addr), .en(en),
    .data(data_h), .data_valid(vld_h)
  );

  rom #(.ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .addr(addr), .en(en),
    .data(data_l), .data_valid(vld_l)
  );

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] addr;
    logic [6:0] exp_d;
    logic       exp_v;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic r, logic e, logic [3:0] a,
                              logic [6:0] d, logic v, string n);
    vec_t x;
    x.rst = r; x.en = e; x.addr = a;
    x.exp_d = d; x.exp_v = v; x.name = n;
    vecs.push_back(x);
  endfunction

  // Compares both instances; the active-low part must show the
  // complement of the active-high expectation, valid unchanged.
  task automatic chk(string n, logic [6:0] d, logic v);
    checks++;
    if (data_h !== d) begin
      failures++;
      $display("FAIL %s data got=%h want=%h", n, data_h, d);
    end
    checks++;
    if (vld_h !== v) begin
      failures++;
      $display("FAIL %s valid got=%b want=%b", n, vld_h, v);
    end
    checks++;
    if (data_l !== ~d) begin
      failures++;
      $display("FAIL %s data_al got=%h want=%h", n, data_l, ~d);
    end
    checks++;
    if (vld_l !== v) begin
      failures++;
      $display("FAIL %s valid_al got=%b want=%b", n, vld_l, v);
    end
  endtask

  // Drive before the edge, check after it, then wiggle inputs
  // mid-cycle and confirm the registered outputs hold.
  task automatic step(logic r, logic e, logic [3:0] a,
                      logic [6:0] d, logic v, string n);
    @(negedge clk);
    rst = r; en = e; addr = a;
    @(posedge clk);
    #1;
    chk(n, d, v);
    addr = ~a;
    en = ~e;
    #2;
    chk({n, "_hold"}, d, v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; addr = 4'h0;

    // reset with en=1, addr=8, then release
    add(1, 1, 4'h8, 7'h00, 0, "rst0");
    add(1, 1, 4'h8, 7'h00, 0, "rst1");
    add(0, 1, 4'h8, 7'h7F, 1, "rst_rel");
    // disabled sweep
    for (int i = 0; i < 16; i++)
      add(0, 0, 4'(i), 7'h00, 0, $sformatf("dis%0d", i));
    // full sweep, ends on F so the next entry is the wrap
    for (int i = 0; i < 16; i++)
      add(0, 1, 4'(i), tbl[i], 1, $sformatf("sweep%0d", i));
    add(0, 1, 4'h0, 7'h3F, 1, "wrap");
    // enable toggle
    add(0, 1, 4'h2, 7'h5B, 1, "tog1");
    add(0, 0, 4'h2, 7'h00, 0, "tog0");
    add(0, 1, 4'h2, 7'h5B, 1, "tog1b");
    // reset mid-stream beats en, next edge reads normally
    add(0, 1, 4'hA, 7'h77, 1, "mid_a");
    add(1, 1, 4'hB, 7'h00, 0, "mid_rst");
    add(0, 1, 4'hC, 7'h39, 1, "mid_c");
    // polarity case: addr 0 enabled then disabled
    add(0, 1, 4'h0, 7'h3F, 1, "pol_en");
    add(0, 0, 4'h0, 7'h00, 0, "pol_dis");

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].en, vecs[i].addr,
           vecs[i].exp_d, vecs[i].exp_v, vecs[i].name);

    // randomized run against the lookup model
    for (int k = 0; k < 400; k++) begin
      logic       r, e;
      logic [3:0] a;
      logic [6:0] d;
      logic       v;
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 3) != 0);
      a = 4'($urandom_range(0, 15));
      v = !r && e;
      d = v ? tbl[a] : 7'h00;
      step(r, e, a, d, v, $sformatf("rnd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
